// File: rtl/seq_alu.sv
// Sequential 16-bit ALU: single-cycle ops finish in one edge, MUL and DIV
// iterate 16 times (shift-add / restoring division) before a one-cycle done pulse.
module seq_alu (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        flag
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    logic [15:0] result_q, result_d;
    logic        flag_q, flag_d;
    logic        done_q, done_d;

    logic [16:0] add_sum;
    logic [16:0] inc_sum;
    logic [16:0] mul_sum;
    logic [31:0] mul_step;
    logic [16:0] div_shift;
    logic        div_ge;
    logic [15:0] div_rem;
    logic [31:0] div_step;

    assign add_sum = {1'b0, a_in} + {1'b0, b_in};
    assign inc_sum = {1'b0, a_in} + 17'd1;

    // MUL: work = {partial product, remaining multiplier}; LSB of multiplier first.
    assign mul_sum  = work_q[0] ? ({1'b0, work_q[31:16]} + {1'b0, a_q})
                                : {1'b0, work_q[31:16]};
    assign mul_step = {mul_sum, work_q[15:1]};

    // DIV: work = {remainder, dividend/quotient}; quotient bits shift in MSB first.
    assign div_shift = {work_q[31:16], work_q[15]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ge ? 16'(div_shift - {1'b0, b_q}) : div_shift[15:0];
    assign div_step  = {div_rem, work_q[14:0], div_ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    case (op)
                        OP_ADD: begin
                            result_d = add_sum[15:0];
                            flag_d   = add_sum[16];
                        end
                        OP_SUB: begin
                            result_d = a_in - b_in;
                            flag_d   = (a_in < b_in);
                        end
                        OP_INC: begin
                            result_d = inc_sum[15:0];
                            flag_d   = inc_sum[16];
                        end
                        OP_SHR: begin
                            result_d = {1'b0, a_in[15:1]};
                            flag_d   = 1'b0;
                        end
                        OP_MUL: begin
                            work_d  = {16'h0000, b_in};
                            state_d = ITER;
                            done_d  = 1'b0;
                        end
                        OP_DIV: begin
                            if (b_in == 16'h0000) begin
                                result_d = 16'hFFFF;
                                flag_d   = 1'b1;
                            end else begin
                                work_d  = {16'h0000, a_in};
                                state_d = ITER;
                                done_d  = 1'b0;
                            end
                        end
                        OP_PASSB: begin
                            result_d = b_in;
                            flag_d   = 1'b0;
                        end
                        default: begin
                            result_d = 16'h0000;
                            flag_d   = 1'b0;
                        end
                    endcase
                end
            end
            ITER: begin
                cnt_d  = cnt_q + 4'd1;
                work_d = (op_q == OP_MUL) ? mul_step : div_step;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (op_q == OP_MUL) begin
                        result_d = mul_step[15:0];
                        flag_d   = |mul_step[31:16];
                    end else begin
                        result_d = div_step[15:0];
                        flag_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cnt_q    <= 4'd0;
            work_q   <= 32'h0000_0000;
            result_q <= 16'h0000;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expected results are queued at issue time and
// popped by a monitor whenever done pulses.
module tb_seq_alu;

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        flag;

    seq_alu dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .result (result),
        .done   (done),
        .busy   (busy),
        .flag   (flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] res;
        logic        flg;
    } exp_t;

    typedef struct {
        logic [2:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        f;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest pending expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (done === 1'b1) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                check("done_has_pending", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_flag", 32'(flag), 32'(e.flg));
            end
        end
        prev_done = done;
    end

    // Caller is positioned just after a negedge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ef);
        int lat;
        int bcnt;
        int exp_lat;
        exp_lat = (o == 3'b100 || (o == 3'b101 && b != 16'h0000)) ? 17 : 1;
        op = o;
        a_in = a;
        b_in = b;
        start = 1'b1;
        sb.push_back('{er, ef});
        @(posedge Clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            lat++;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) sb.delete();
        $display("op=%0d a=%h b=%h result=%h flag=%b latency=%0d", o, a, b, result, flag, lat);
        check($sformatf("latency_op%0d", o), 32'(lat), 32'(exp_lat));
        check($sformatf("busy_cycles_op%0d", o), 32'(bcnt), 32'(exp_lat));
        @(negedge Clk);
        check("done_low_after", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        check("result_held", 32'(result), 32'(er));
        check("flag_held", 32'(flag), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         ndone;
        logic [7:0] pat;

        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[1]  = '{3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0};
        vecs[2]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1};
        vecs[3]  = '{3'd1, 16'h0009, 16'h0003, 16'h0006, 1'b0};
        vecs[4]  = '{3'd2, 16'h0041, 16'h7777, 16'h0042, 1'b0};
        vecs[5]  = '{3'd2, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{3'd3, 16'h8001, 16'h0000, 16'h4000, 1'b0};
        vecs[7]  = '{3'd6, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[8]  = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
        vecs[9]  = '{3'd4, 16'h0123, 16'h0045, 16'h4E6F, 1'b0};
        vecs[10] = '{3'd4, 16'h0100, 16'h0100, 16'h0000, 1'b1};
        vecs[11] = '{3'd4, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[12] = '{3'd5, 16'h00FF, 16'h0010, 16'h000F, 1'b0};
        vecs[13] = '{3'd5, 16'h1234, 16'h0000, 16'hFFFF, 1'b1};
        vecs[14] = '{3'd5, 16'hFFFF, 16'h0007, 16'h2492, 1'b0};
        vecs[15] = '{3'd5, 16'h0003, 16'h0007, 16'h0000, 1'b0};

        // Reset with start asserted: must stay idle.
        Rst   = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        a_in  = 16'h0001;
        b_in  = 16'h0001;
        repeat (3) @(negedge Clk);
        check("rst_result", 32'(result), 32'h0000);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);

        // First op accepted on the first edge after reset release.
        Rst = 1'b0;
        foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);

        // MUL with start re-pulsed and operands changed mid-iteration.
        op = 3'd4; a_in = 16'h0123; b_in = 16'h0045; start = 1'b1;
        sb.push_back('{16'h4E6F, 1'b0});
        @(posedge Clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge Clk);
            if (i == 3) begin
                start = 1'b1; op = 3'd0; a_in = 16'hFFFF; b_in = 16'hFFFF;
            end
            if (done === 1'b1) begin
                ndone++;
                start = 1'b0;
            end
        end
        $display("op=4 restart-during-iter result=%h flag=%b dones=%0d", result, flag, ndone);
        check("restart_done_count", 32'(ndone), 32'd1);
        check("restart_result", 32'(result), 32'h4E6F);
        check("restart_idle", 32'(busy), 32'd0);

        // Reset at iteration 8 of a DIV.
        op = 3'd5; a_in = 16'h00FF; b_in = 16'h0010; start = 1'b1;
        sb.push_back('{16'h000F, 1'b0});
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (8) @(posedge Clk);
        #1 Rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_result", 32'(result), 32'h0000);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        start = 1'b1; op = 3'd0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (done === 1'b1) ndone++;
        end
        $display("op=5 reset-mid-div result=%h busy=%b dones=%0d", result, busy, ndone);
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_start_ignored", 32'(busy), 32'd0);
        Rst = 1'b0;
        start = 1'b0;
        run_op(3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1);

        // start held high with INC: accepted every other cycle.
        op = 3'd2; a_in = 16'h0010; b_in = 16'h0000; start = 1'b1;
        repeat (4) sb.push_back('{16'h0011, 1'b0});
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            if (i == 6) start = 1'b0;
            @(negedge Clk);
            pat[i] = done;
        end
        $display("op=2 back-to-back a=0010 done_pattern=%b result=%h", pat, result);
        check("b2b_done_pattern", 32'(pat), 32'h55);
        check("b2b_all_consumed", 32'(sb.size()), 32'd0);
        check("b2b_result", 32'(result), 32'h0011);

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: requests an operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3 bits: operation select, captured with start.
REQ-005 SHALL have port a_in, input, 16 bits: operand A (accumulator value), captured with start.
REQ-006 SHALL have port b_in, input, 16 bits: operand B (bus/memory word), captured with start.
REQ-007 SHALL have port result, output, 16 bits, registered: the operation result; it drives the accumulator load input.
REQ-008 SHALL have port done, output, 1 bit, registered: a one-cycle pulse marking result valid; it drives the accumulator load strobe.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port flag, output, 1 bit, registered: carry/borrow/overflow/error, valid with done.

Function
REQ-011 SHALL implement op codes: 000 ADD a+b; 001 SUB a-b; 010 INC a+1; 011 SHR a>>1 (logical); 100 MUL low 16 bits of a*b; 101 DIV unsigned floor(a/b); 110 PASSB b; 111 reserved, result 16'h0000.
REQ-012 SHALL be a state machine with states IDLE, ITER and DONE.
REQ-013 SHALL, in IDLE with start=1 at edge N, capture op, a_in and b_in; later input changes SHALL NOT affect the running operation.
REQ-014 SHALL, for single-cycle ops (ADD, SUB, INC, SHR, PASSB, reserved, DIV with b=0), load result and flag at edge N and go to DONE; done is high for the cycle after edge N.
REQ-015 SHALL, for MUL and for DIV with b!=0, go to ITER at edge N and run exactly 16 iterations on edges N+1..N+16 under a 4-bit counter, then go to DONE at edge N+16; done is high for the cycle after edge N+16.
REQ-016 SHALL compute MUL by shift-add, one multiplier bit per iteration, with a 32-bit internal product.
REQ-017 SHALL compute DIV by restoring division, one quotient bit per iteration, MSB first.
REQ-018 SHALL return from DONE to IDLE unconditionally on the next edge, so done is never high for two consecutive cycles.
REQ-019 SHALL ignore start in ITER and DONE: no queuing and no restart. A new request is accepted at the earliest on the edge after DONE.
REQ-020 SHALL hold result and flag unchanged from one done until the next op's completion edge.
REQ-021 SHALL set flag as follows: ADD carry-out of bit 15; SUB 1 if a<b (borrow); INC carry-out; MUL 1 if product[31:16]!=0; DIV 1 if b=0; all others 0.
REQ-022 SHALL return result 16'hFFFF with flag=1 for DIV with b=0.
REQ-023 SHALL wrap all arithmetic modulo 2^16: FFFF+1=0000 with flag=1; 0000-0001=FFFF with flag=1.

Reset
REQ-024 SHALL, on Rst=1 at any time including mid-ITER, immediately force: state IDLE, result 16'h0000, done 0, busy 0, flag 0, counter 0.
REQ-025 SHALL abandon any in-flight operation on reset with no done pulse, and ignore start while Rst=1.
REQ-026 SHALL accept start on the first rising edge after Rst deasserts.

Verification
REQ-027 ADD a=FFFF b=0001 -> after 1 edge result=0000, flag=1, done for exactly one cycle.
REQ-028 MUL a=0123 b=0045 -> busy for 17 cycles, done after edge N+16, result=4E6F, flag=0; a=0100 b=0100 -> result=0000, flag=1.
REQ-029 DIV a=00FF b=0010 -> done after edge N+16, result=000F, flag=0; DIV a=1234 b=0000 -> done after 1 edge, result=FFFF, flag=1.
REQ-030 start re-pulsed and a_in/b_in changed during MUL ITER -> result still matches the captured operands, exactly one done, and the second start is not executed.
REQ-031 Rst asserted at iteration 8 of DIV -> result=0000, busy=0, no done; a new SUB a=0005 b=0007 -> result=FFFE, flag=1.
REQ-032 Back-to-back: start held high continuously with op=INC a=0010 -> an op is accepted every 2 cycles, done pulses separated by one low cycle, result=0011 each time.
